// File: rtl/comparator_serial_if.sv
// Operand/result handshake bundle for the bit-serial magnitude comparator.
interface comparator_serial_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic             l;
  logic             g;
  logic             e;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, l, g, e
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, l, g, e
  );
endinterface

// File: rtl/comparator_serial.sv
// Bit-serial unsigned magnitude comparator: MSB-first, first differing bit pair
// decides, one-hot l/g/e result held until consumed.
module comparator_serial #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  comparator_serial_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // 1-bit compare cell, returns {a<b, a>b}; equality is the absence of both.
  function automatic logic [1:0] cmp_cell(input logic x, input logic y);
    return {~x & y, x & ~y};
  endfunction

  state_t           state_r;
  logic [WIDTH-1:0] sa_r;
  logic [WIDTH-1:0] sb_r;
  logic [CW-1:0]    cnt_r;
  logic             decided_r;
  logic             lt_r;
  logic             gt_r;
  logic             in_ready_r;
  logic             out_valid_r;
  logic             l_r;
  logic             g_r;
  logic             e_r;

  logic [1:0]       cell_s;
  logic             decided_nx_s;
  logic             lt_nx_s;
  logic             gt_nx_s;

  // Decision update for the current MSB pair; only the first difference counts.
  always_comb begin
    cell_s       = cmp_cell(sa_r[WIDTH-1], sb_r[WIDTH-1]);
    decided_nx_s = decided_r;
    lt_nx_s      = lt_r;
    gt_nx_s      = gt_r;
    if (!decided_r && (cell_s != 2'b00)) begin
      decided_nx_s = 1'b1;
      lt_nx_s      = cell_s[1];
      gt_nx_s      = cell_s[0];
    end else begin
      decided_nx_s = decided_r;
      lt_nx_s      = lt_r;
      gt_nx_s      = gt_r;
    end
  end

  // Control FSM with datapath and registered handshake/result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      sa_r        <= {WIDTH{1'b0}};
      sb_r        <= {WIDTH{1'b0}};
      cnt_r       <= {CW{1'b0}};
      decided_r   <= 1'b0;
      lt_r        <= 1'b0;
      gt_r        <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      l_r         <= 1'b0;
      g_r         <= 1'b0;
      e_r         <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          out_valid_r <= 1'b0;
          l_r         <= 1'b0;
          g_r         <= 1'b0;
          e_r         <= 1'b0;
          if (bus.in_valid) begin
            sa_r       <= bus.a;
            sb_r       <= bus.b;
            cnt_r      <= CW'(WIDTH - 1);
            decided_r  <= 1'b0;
            lt_r       <= 1'b0;
            gt_r       <= 1'b0;
            in_ready_r <= 1'b0;
            state_r    <= SHIFT;
          end else begin
            in_ready_r <= 1'b1;
            state_r    <= IDLE;
          end
        end
        SHIFT: begin
          sa_r      <= {sa_r[WIDTH-2:0], 1'b0};
          sb_r      <= {sb_r[WIDTH-2:0], 1'b0};
          decided_r <= decided_nx_s;
          lt_r      <= lt_nx_s;
          gt_r      <= gt_nx_s;
          // The result is published straight from the next-state flags so
          // out_valid rises on the same edge as the final bit is examined.
          if (cnt_r == {CW{1'b0}}) begin
            out_valid_r <= 1'b1;
            l_r         <= lt_nx_s;
            g_r         <= gt_nx_s;
            e_r         <= ~decided_nx_s;
            state_r     <= DONE;
          end else begin
            cnt_r   <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
            state_r <= SHIFT;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            l_r         <= 1'b0;
            g_r         <= 1'b0;
            e_r         <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= IDLE;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          state_r     <= IDLE;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
          l_r         <= 1'b0;
          g_r         <= 1'b0;
          e_r         <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.l         = l_r;
  assign bus.g         = g_r;
  assign bus.e         = e_r;

endmodule

// File: tb/tb_comparator_serial.sv
// Self-checking bench for comparator_serial: directed corner cases plus
// randomized operands checked against a plain-arithmetic reference.
module tb_comparator_serial;

  localparam int WIDTH = 8;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  comparator_serial_if #(.WIDTH(WIDTH)) bus ();

  comparator_serial #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Runs one full transaction starting at a negedge while the DUT is idle.
  task automatic do_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                       input int hold, input bit keep_valid, input bit junk);
    logic exp_l, exp_g, exp_e;
    exp_l = (av < bv);
    exp_g = (av > bv);
    exp_e = (av == bv);
    check("accept_ready", bus.in_ready, 32'd1);
    bus.in_valid  = 1'b1;
    bus.a         = av;
    bus.b         = bv;
    bus.out_ready = (hold == 0);
    for (int i = 0; i < WIDTH; i++) begin
      @(negedge clk);
      check("shift_no_valid", bus.out_valid, 32'd0);
      check("shift_not_ready", bus.in_ready, 32'd0);
      check("shift_e_low", bus.e, 32'd0);
      bus.in_valid = keep_valid;
      bus.a = WIDTH'($urandom);
      bus.b = WIDTH'($urandom);
      if (junk && i == 1) begin
        bus.in_valid = 1'b1;
        bus.a = '0;
        bus.b = '0;
      end
    end
    @(negedge clk);
    check("res_valid", bus.out_valid, 32'd1);
    check("res_l", bus.l, 32'(exp_l));
    check("res_g", bus.g, 32'(exp_g));
    check("res_e", bus.e, 32'(exp_e));
    check("res_not_ready", bus.in_ready, 32'd0);
    for (int h = 1; h < hold; h++) begin
      @(negedge clk);
      check("hold_valid", bus.out_valid, 32'd1);
      check("hold_lge", {29'd0, bus.l, bus.g, bus.e}, {29'd0, exp_l, exp_g, exp_e});
      check("hold_not_ready", bus.in_ready, 32'd0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("consumed_valid", bus.out_valid, 32'd0);
    check("consumed_ready", bus.in_ready, 32'd1);
    check("consumed_lge", {29'd0, bus.l, bus.g, bus.e}, 32'd0);
    bus.out_ready = 1'b0;
    if (!keep_valid) bus.in_valid = 1'b0;
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b0;

    @(negedge clk);
    check("rst_ready", bus.in_ready, 32'd1);
    check("rst_valid", bus.out_valid, 32'd0);
    check("rst_lge", {29'd0, bus.l, bus.g, bus.e}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_ready", bus.in_ready, 32'd1);
    check("idle_valid", bus.out_valid, 32'd0);

    do_op(8'h5A, 8'h5A, 0, 1'b0, 1'b0);
    do_op(8'h80, 8'h7F, 0, 1'b0, 1'b0);
    do_op(8'h12, 8'h13, 0, 1'b0, 1'b0);
    do_op(8'h00, 8'hFF, 0, 1'b0, 1'b0);
    do_op(8'h03, 8'h01, 5, 1'b0, 1'b1);
    do_op(8'hFF, 8'h00, 2, 1'b1, 1'b0);
    do_op(8'h01, 8'h00, 0, 1'b0, 1'b0);

    for (int k = 0; k < 40; k++) begin
      do_op(WIDTH'($urandom), WIDTH'($urandom), int'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    bus.in_valid = 1'b0;

    // Reset in the middle of SHIFT discards the operation.
    bus.in_valid  = 1'b1;
    bus.a         = 8'hF0;
    bus.b         = 8'h0F;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_ready", bus.in_ready, 32'd1);
    check("midrst_valid", bus.out_valid, 32'd0);
    @(negedge clk);
    check("midrst_hold_ready", bus.in_ready, 32'd1);
    rst = 1'b0;
    for (int i = 0; i < WIDTH + 4; i++) begin
      @(negedge clk);
      check("midrst_no_valid", bus.out_valid, 32'd0);
    end
    bus.out_ready = 1'b0;
    do_op(8'h01, 8'h02, 0, 1'b0, 1'b0);

    // Asynchronous reset between edges while a result is held in DONE.
    bus.in_valid  = 1'b1;
    bus.a         = 8'hAA;
    bus.b         = 8'h55;
    bus.out_ready = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (WIDTH) @(negedge clk);
    check("done_valid", bus.out_valid, 32'd1);
    check("done_g", bus.g, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async_valid", bus.out_valid, 32'd0);
    check("async_lge", {29'd0, bus.l, bus.g, bus.e}, 32'd0);
    check("async_ready", bus.in_ready, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_async_valid", bus.out_valid, 32'd0);
    check("post_async_ready", bus.in_ready, 32'd1);
    do_op(8'h7F, 8'h80, 1, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
